// File: rtl/vend_ctrl_if.sv
// ----------------------------------------------------------------------------
// vend_ctrl_if
// Coin-slot handshake bundle between the coin acceptor front-ends (master)
// and the vend controller (slave).
//
// Signals:
//   coin_req [1:0]  per-slot coin-present request (slot A = bit 0, B = bit 1)
//   coin_a   [1:0]  slot A coin code
//   coin_b   [1:0]  slot B coin code
//   cancel          refund request
//   coin_ack [1:0]  one-hot grant back to the front-ends (combinational)
// ----------------------------------------------------------------------------
interface vend_ctrl_if;
  logic [1:0] coin_req;
  logic [1:0] coin_a;
  logic [1:0] coin_b;
  logic       cancel;
  logic [1:0] coin_ack;

  modport master (
    output coin_req,
    output coin_a,
    output coin_b,
    output cancel,
    input  coin_ack
  );

  modport slave (
    input  coin_req,
    input  coin_a,
    input  coin_b,
    input  cancel,
    output coin_ack
  );
endinterface

// File: rtl/vend_ctrl.sv
// ----------------------------------------------------------------------------
// vend_ctrl
// Coin-vend controller: round-robin arbitration of two coin slots into one
// credit accumulator, then sequencing of item dispense and change return.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   coin          vend_ctrl_if.slave (coin_req, coin_a, coin_b, cancel, coin_ack)
//   dispense      one-cycle item-release pulse
//   change_pulse  one pulse per 5 units of change returned
//   busy          high whenever the controller is outside COLLECT
//   credit        current credit register
//
// Optional feature: define IDLE_REFUND_EN to refund all credit after TIMEOUT
// idle cycles in COLLECT. Without it, TIMEOUT is unused and credit is held
// indefinitely.
//
// State table:
//   state      | meaning
//   S_COLLECT  | accepting coins, waiting for credit >= PRICE or cancel
//   S_DISPENSE | one cycle, item release; PRICE deducted on exit
//   S_CHANGE   | returning change, 5 units per cycle until credit is 0
// ----------------------------------------------------------------------------
module vend_ctrl #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6,
  parameter int TIMEOUT  = 100
) (
  input  logic                clk,
  input  logic                reset,
  vend_ctrl_if.slave          coin,
  output logic                dispense,
  output logic                change_pulse,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_DISPENSE = 2'd1,
    S_CHANGE   = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);

  state_t              r_state;
  logic                r_last;       // slot accepted most recently (0 = A, 1 = B)
  logic [CREDIT_W-1:0] r_credit;
  logic                r_dispense;
  logic                r_change;
  logic                r_busy;

  logic [1:0]          w_grant;
  logic [1:0]          w_code;
  logic [CREDIT_W-1:0] w_value;
  logic [CREDIT_W-1:0] w_sum;
  logic                w_accept;

`ifdef IDLE_REFUND_EN
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT - 1);
  // Down-counter: terminal count 0 marks the TIMEOUT-th idle cycle.
  logic [IDLE_W-1:0] r_idle;
`endif

  // Grant only in COLLECT and never while cancel is high. With both slots
  // requesting, the slot that did not win last time gets the grant.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == S_COLLECT && !coin.cancel) begin
      case (coin.coin_req)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    w_code = w_grant[1] ? coin.coin_b : coin.coin_a;
    case (w_code)
      2'b01:   w_value = CREDIT_W'(5);
      2'b10:   w_value = CREDIT_W'(10);
      2'b11:   w_value = CREDIT_W'(25);
      default: w_value = '0;
    endcase
  end

  assign w_accept      = |w_grant;
  assign w_sum         = r_credit + w_value;
  assign coin.coin_ack = w_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_COLLECT;
      r_last     <= 1'b1;          // "B last" so that A wins the first tie
      r_credit   <= '0;
      r_dispense <= 1'b0;
      r_change   <= 1'b0;
      r_busy     <= 1'b0;
`ifdef IDLE_REFUND_EN
      r_idle     <= IDLE_LOAD;
`endif
    end else begin
`ifdef IDLE_REFUND_EN
      // Reloads on every path except a genuine idle cycle below.
      r_idle <= IDLE_LOAD;
`endif
      case (r_state)
        S_COLLECT: begin
          if (coin.cancel) begin
            if (r_credit != '0) begin
              r_state  <= S_CHANGE;
              r_change <= 1'b1;
              r_busy   <= 1'b1;
            end
          end else if (w_accept) begin
            r_credit <= w_sum;
            r_last   <= w_grant[1];
            if (w_sum >= PRICE_C) begin
              r_state    <= S_DISPENSE;
              r_dispense <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
`ifdef IDLE_REFUND_EN
          else if (r_credit != '0) begin
            if (r_idle == '0) begin
              r_state  <= S_CHANGE;
              r_change <= 1'b1;
              r_busy   <= 1'b1;
            end else begin
              r_idle <= r_idle - 1'b1;
            end
          end
`endif
        end

        S_DISPENSE: begin
          r_credit   <= r_credit - PRICE_C;
          r_dispense <= 1'b0;
          if (r_credit != PRICE_C) begin
            r_state  <= S_CHANGE;
            r_change <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_state <= S_COLLECT;
            r_busy  <= 1'b0;
          end
        end

        S_CHANGE: begin
          r_credit <= r_credit - FIVE_C;
          // Leave on the edge where credit reaches zero: N*5 -> N pulses.
          if (r_credit == FIVE_C) begin
            r_state  <= S_COLLECT;
            r_change <= 1'b0;
            r_busy   <= 1'b0;
          end
        end

        default: begin
          r_state    <= S_COLLECT;
          r_credit   <= '0;
          r_dispense <= 1'b0;
          r_change   <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign dispense     = r_dispense;
  assign change_pulse = r_change;
  assign busy         = r_busy;
  assign credit       = r_credit;

endmodule

// File: tb/tb_vend_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vend_ctrl
// Directed bench for vend_ctrl (PRICE = 15, CREDIT_W = 6, TIMEOUT = 4).
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge, i.e. they show the state before the next rising edge.
// ----------------------------------------------------------------------------
module tb_vend_ctrl;

  localparam int PRICE    = 15;
  localparam int CREDIT_W = 6;
  localparam int TIMEOUT  = 4;

  logic                clk;
  logic                reset;
  logic                dispense;
  logic                change_pulse;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  vend_ctrl_if u_if ();

  vend_ctrl #(
    .PRICE    (PRICE),
    .CREDIT_W (CREDIT_W),
    .TIMEOUT  (TIMEOUT)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .coin         (u_if),
    .dispense     (dispense),
    .change_pulse (change_pulse),
    .busy         (busy),
    .credit       (credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] ack, input logic disp,
                            input logic chg, input logic bsy, input int cred);
    check({tag, " coin_ack"},     int'(u_if.coin_ack), int'(ack));
    check({tag, " dispense"},     int'(dispense),      int'(disp));
    check({tag, " change_pulse"}, int'(change_pulse),  int'(chg));
    check({tag, " busy"},         int'(busy),          int'(bsy));
    check({tag, " credit"},       int'(credit),        cred);
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] a,
                       input logic [1:0] b, input logic cxl);
    u_if.coin_req = req;
    u_if.coin_a   = a;
    u_if.coin_b   = b;
    u_if.cancel   = cxl;
  endtask

  // Advance to the next rising edge, then settle inputs after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] a;
    logic [1:0] b;
    logic       cxl;
    logic [1:0] exp_ack;
    logic       exp_disp;
    logic       exp_chg;
    logic       exp_busy;
    int         exp_credit;
  } vec_t;

  vec_t vecs [0:25];

  initial begin
    // req    a      b      cxl   ack    disp  chg   busy  credit
    // A inserts 10, B inserts 10 -> 20: dispense, 1 change pulse
    vecs[0]  = '{2'b01, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 10};
    vecs[2]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 20};
    vecs[3]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 5};
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0};
    // both slots request 5 three times: A, B, A -> 15, dispense, no change
    vecs[5]  = '{2'b11, 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{2'b11, 2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 5};
    vecs[7]  = '{2'b11, 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 10};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 15};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0};
    // reject code on B: acked, adds nothing
    vecs[10] = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 0};
    vecs[11] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0};
    // cancel with zero credit: ignored but blocks the ack
    vecs[12] = '{2'b01, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 0};
    vecs[13] = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 0};
    // credit 5, cancel with B requesting: no ack, 1 pulse, B served after
    vecs[14] = '{2'b10, 2'b00, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5};
    vecs[15] = '{2'b10, 2'b00, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 5};
    vecs[16] = '{2'b10, 2'b00, 2'b01, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 0};
    // refund that 5 again
    vecs[17] = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5};
    vecs[18] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 5};
    vecs[19] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0};
    // 25 at PRICE 15 with A held: dispense, 2 pulses, A acked after busy
    vecs[20] = '{2'b01, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 0};
    vecs[21] = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 25};
    vecs[22] = '{2'b01, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 10};
    vecs[23] = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 5};
    vecs[24] = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 0};
    vecs[25] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5};
  end

  initial begin
    reset = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    repeat (2) @(posedge clk);

    // Run briefly, then reset mid-stream
    #1 reset = 1'b1;
    drive(2'b01, 2'b10, 2'b00, 1'b0);
    step();
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Table-driven vectors
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].cxl);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_disp,
                 vecs[i].exp_chg, vecs[i].exp_busy, vecs[i].exp_credit);
      step();
    end

    // Credit 5 now. Insert 25 -> 30, dispense, then reset during CHANGE.
    drive(2'b01, 2'b11, 2'b00, 1'b0);
    @(negedge clk);
    check_outs("midrst accept", 2'b01, 1'b0, 1'b0, 1'b0, 5);
    step();
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    check_outs("midrst disp", 2'b00, 1'b1, 1'b0, 1'b1, 30);
    step();
    @(negedge clk);
    check_outs("midrst chg", 2'b00, 1'b0, 1'b1, 1'b1, 15);
    reset = 1'b0;
    #1;
    check_outs("midrst asserted", 2'b00, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("midrst after%0d", i), 2'b00, 1'b0, 1'b0, 1'b0, 0);
    end
    step();

`ifdef IDLE_REFUND_EN
    // Insert 10, then idle: refund after TIMEOUT idle cycles
    drive(2'b01, 2'b10, 2'b00, 1'b0);
    step();
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      check_outs($sformatf("idle%0d", i), 2'b00, 1'b0, 1'b0, 1'b0, 10);
    end
    @(negedge clk);
    check_outs("idle chg0", 2'b00, 1'b0, 1'b1, 1'b1, 10);
    @(negedge clk);
    check_outs("idle chg1", 2'b00, 1'b0, 1'b1, 1'b1, 5);
    @(negedge clk);
    check_outs("idle done", 2'b00, 1'b0, 1'b0, 1'b0, 0);
`else
    // Insert 10, then idle well past TIMEOUT: credit must be held
    drive(2'b01, 2'b10, 2'b00, 1'b0);
    step();
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    repeat (3 * TIMEOUT) @(posedge clk);
    @(negedge clk);
    check_outs("hold", 2'b00, 1'b0, 1'b0, 1'b0, 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
